// File: rtl/prog_counter_pkg.sv
// Shared definitions for the programmable counter: mode encodings and the
// one-shot sequencer state type.
package prog_counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP     = 2'b00,
    MODE_SAT      = 2'b01,
    MODE_ONESHOT  = 2'b10,
    MODE_WRAP_ALT = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } os_state_e;

endpackage

// File: rtl/prog_counter_tick.sv
// Enable-gated prescaler: emits one tick every presc+1 enabled cycles and
// restarts from zero on a synchronous clear.
module tick_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == presc);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter with wrap, saturate and one-shot modes,
// driven by a prescaled tick; all outputs are registered.
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               dir,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   modulo,
  input  logic [PRESC_W-1:0] presc,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic               start,
  output logic [WIDTH-1:0]   count,
  output logic               tc,
  output logic               done,
  output logic               running
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  logic             running_q, running_d;
  os_state_e        state_q, state_d;

  mode_e            mode_m;
  logic             oneshot;
  logic             start_eff;
  logic             presc_clr;
  logic             tick;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] restart_val;
  logic [WIDTH-1:0] step_val;
  logic             at_term;
  logic             over;

  assign mode_m      = mode_e'(mode);
  assign oneshot     = (mode_m == MODE_ONESHOT);
  assign start_eff   = start && oneshot;
  assign presc_clr   = load || start_eff;
  assign term        = dir ? modulo : '0;
  assign restart_val = dir ? '0 : modulo;
  assign step_val    = dir ? (count_q + 1'b1) : (count_q - 1'b1);
  assign at_term     = (count_q == term);
  assign over        = (count_q > modulo);

  tick_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clr   (presc_clr),
    .presc (presc),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    count_d   = count_q;
    tc_d      = 1'b0;
    done_d    = done_q;
    state_d   = state_q;
    running_d = 1'b0;

    if (load) begin
      count_d = (load_val > modulo) ? modulo : load_val;
    end else if (start_eff) begin
      count_d = restart_val;
      state_d = ST_RUN;
      done_d  = 1'b0;
    end else if (tick && (!oneshot || state_q == ST_RUN)) begin
      if (over) begin
        // modulo was lowered under the count: snap to the terminal value silently
        count_d = term;
      end else if (mode_m == MODE_SAT || oneshot) begin
        if (!at_term) begin
          count_d = step_val;
          tc_d    = (step_val == term);
        end
      end else if (at_term) begin
        count_d = restart_val;
        tc_d    = 1'b1;
      end else begin
        count_d = step_val;
      end

      if (oneshot && count_d == term) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
    end

    if (!oneshot) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
    end

    running_d = en && (!oneshot || state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      tc_q      <= 1'b0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      tc_q      <= tc_d;
      done_q    <= done_d;
      running_q <= running_d;
    end
  end

  assign count   = count_q;
  assign tc      = tc_q;
  assign done    = done_q;
  assign running = running_q;

endmodule

// File: tb/tb_prog_counter.sv
// Self-checking bench for prog_counter: directed vector table, a few
// hand-written reset sequences, then randomized traffic against a model.
module tb_prog_counter;

  localparam int W  = 8;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          en = 1'b0;
  logic          dir = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [W-1:0]  modulo = '0;
  logic [PW-1:0] presc = '0;
  logic          load = 1'b0;
  logic [W-1:0]  load_val = '0;
  logic          start = 1'b0;
  logic [W-1:0]  count;
  logic          tc;
  logic          done;
  logic          running;

  int n_cmp = 0;
  int n_bad = 0;

  prog_counter #(
    .WIDTH   (W),
    .PRESC_W (PW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .dir      (dir),
    .mode     (mode),
    .modulo   (modulo),
    .presc    (presc),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .count    (count),
    .tc       (tc),
    .done     (done),
    .running  (running)
  );

  always #5 clk = ~clk;

  typedef struct {
    int en, dir, mode, modulo, presc, load, load_val, start;
    int e_count, e_tc, e_done, e_run;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int en_, input int dir_, input int mode_,
                              input int mod_, input int pr_, input int ld_,
                              input int lv_, input int st_, input int c_,
                              input int t_, input int d_, input int r_);
    vec_t v;
    v.en = en_; v.dir = dir_; v.mode = mode_; v.modulo = mod_; v.presc = pr_;
    v.load = ld_; v.load_val = lv_; v.start = st_;
    v.e_count = c_; v.e_tc = t_; v.e_done = d_; v.e_run = r_;
    vecs.push_back(v);
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all(input string nm, input int c, input int t,
                           input int d, input int r);
    check({nm, ".count"},   int'(count),   c);
    check({nm, ".tc"},      int'(tc),      t);
    check({nm, ".done"},    int'(done),    d);
    check({nm, ".running"}, int'(running), r);
  endtask

  task automatic drive(input vec_t v);
    en       = (v.en != 0);
    dir      = (v.dir != 0);
    mode     = 2'(v.mode);
    modulo   = W'(v.modulo);
    presc    = PW'(v.presc);
    load     = (v.load != 0);
    load_val = W'(v.load_val);
    start    = (v.start != 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model: counter behaviour from the mode rules, in plain integers.
  int m_count, m_pc, m_state, m_tc, m_done, m_run; // m_state: 0 idle, 1 run, 2 done

  task automatic model_reset();
    m_count = 0; m_pc = 0; m_state = 0; m_tc = 0; m_done = 0; m_run = 0;
  endtask

  task automatic model_step();
    int  md, term, nxt;
    bit  os, tk, go;
    md   = int'(modulo);
    os   = (mode == 2'b10);
    go   = start && os;
    tk   = en && (m_pc == int'(presc));
    term = dir ? md : 0;
    m_tc = 0;

    if (load || go)  m_pc = 0;
    else if (tk)     m_pc = 0;
    else if (en)     m_pc = (m_pc + 1) % (1 << PW);

    if (load) begin
      m_count = (int'(load_val) < md) ? int'(load_val) : md;
    end else if (go) begin
      m_count = dir ? 0 : md;
      m_state = 1;
      m_done  = 0;
    end else if (tk && (!os || m_state == 1)) begin
      if (m_count > md) begin
        m_count = term;
      end else if (mode == 2'b01 || os) begin
        if (dir) nxt = (m_count + 1 > md) ? md : m_count + 1;
        else     nxt = (m_count == 0) ? 0 : m_count - 1;
        m_tc    = (nxt != m_count && nxt == term) ? 1 : 0;
        m_count = nxt;
      end else begin
        m_tc    = (m_count == term) ? 1 : 0;
        m_count = dir ? (m_count + 1) % (md + 1) : (m_count + md) % (md + 1);
      end
      if (os && m_count == term) begin
        m_state = 2;
        m_done  = 1;
      end
    end

    if (!os) begin
      m_state = 0;
      m_done  = 0;
    end
    m_run = (en && (!os || m_state == 1)) ? 1 : 0;
  endtask

  initial begin
    // wrap, up, modulo 9, every cycle a tick; then bring count to 5
    for (int k = 1; k <= 15; k++) add(1, 1, 0, 9, 0, 0, 0, 0, k % 10, (k == 10) ? 1 : 0, 0, 1);
    // load beats tick and is clamped to modulo
    add(1, 1, 0, 50, 0, 1, 200, 0, 50, 0, 0, 1);
    add(1, 1, 0, 50, 0, 0, 0, 0, 0, 1, 0, 1);
    // saturate down from 3 with presc=2
    add(1, 0, 1, 50, 2, 1, 3, 0, 3, 0, 0, 1);
    for (int k = 1; k <= 12; k++) add(1, 0, 1, 50, 2, 0, 0, 0, (3 - k / 3 < 0) ? 0 : 3 - k / 3, (k == 9) ? 1 : 0, 0, 1);
    // wrap with modulo 0: tc every tick; then en=0 freezes
    for (int k = 0; k < 3; k++) add(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    for (int k = 0; k < 2; k++) add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // one-shot up to 4, then restart
    add(1, 1, 2, 4, 0, 0, 0, 1, 0, 0, 0, 1);
    for (int k = 1; k <= 3; k++) add(1, 1, 2, 4, 0, 0, 0, 0, k, 0, 0, 1);
    add(1, 1, 2, 4, 0, 0, 0, 0, 4, 1, 1, 0);
    add(1, 1, 2, 4, 0, 0, 0, 0, 4, 0, 1, 0);
    add(1, 1, 2, 4, 0, 0, 0, 1, 0, 0, 0, 1);
    add(1, 1, 2, 4, 0, 0, 0, 0, 1, 0, 0, 1);

    reset = 1'b1;
    cycle();
    cycle();
    check_all("reset", 0, 0, 0, 0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      cycle();
      check_all($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_tc, vecs[i].e_done, vecs[i].e_run);
    end

    // reset in the middle of a one-shot run, then idle until a new start
    cycle();
    check("os_mid.count", int'(count), 2);
    #2 reset = 1'b1;
    #1 check_all("async_reset", 0, 0, 0, 0);
    cycle();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check_all($sformatf("post_reset%0d", k), 0, 0, 0, 0);
    end
    start = 1'b1;
    cycle();
    check_all("restart", 0, 0, 0, 1);
    start = 1'b0;
    cycle();
    check_all("restart_step", 1, 0, 0, 1);

    // randomized traffic against the model
    reset = 1'b1;
    #1 model_reset();
    cycle();
    reset = 1'b0;
    en = 1'b1; dir = 1'b1; mode = 2'b00; modulo = W'(7); presc = '0;
    load = 1'b0; start = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      en    = ($urandom_range(0, 99) < 85);
      if ($urandom_range(0, 99) < 5) dir = ~dir;
      if ($urandom_range(0, 99) < 2) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 2) modulo = W'($urandom_range(0, 20));
      if ($urandom_range(0, 99) < 3) presc = PW'($urandom_range(0, 3));
      load     = ($urandom_range(0, 99) < 3);
      load_val = W'($urandom_range(0, 30));
      start    = ($urandom_range(0, 99) < 5);
      if (reset) begin
        #1 model_reset();
        check_all("rnd_reset", m_count, m_tc, m_done, m_run);
      end
      @(posedge clk);
      if (!reset) model_step();
      #1;
      check_all($sformatf("rnd%0d", c), m_count, m_tc, m_done, m_run);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_counter.md
PROG_COUNTER -- requirements
Module: prog_counter

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits, legal range 2..16.
REQ-002 Parameter PRESC_W, default 8: prescaler width in bits.
REQ-003 Port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 Port reset  in  1  asynchronous, active-high reset.
REQ-005 Port en  in  1  count enable; gates the prescaler and the counter.
REQ-006 Port dir  in  1  count direction; 1 = up, 0 = down.
REQ-007 Port mode  in  2  counting mode; 00 = wrap, 01 = saturate, 10 = one-shot, 11 = treated as wrap.
REQ-008 Port modulo  in  WIDTH  terminal value; the count range is 0..modulo.
REQ-009 Port presc  in  PRESC_W  one tick every presc+1 enabled cycles.
REQ-010 Port load  in  1  synchronous load strobe.
REQ-011 Port load_val  in  WIDTH  load data.
REQ-012 Port start  in  1  one-shot start/restart strobe.
REQ-013 Port count  out  WIDTH  current count, registered.
REQ-014 Port tc  out  1  terminal-count pulse, registered, one cycle wide.
REQ-015 Port done  out  1  one-shot complete, registered level.
REQ-016 Port running  out  1  counter is advancing on ticks, registered.

Function
REQ-017 Prescaler: while en=1, it increments each cycle; when it equals presc, it asserts tick and returns to 0 on the same edge. presc=0 gives a tick every enabled cycle. It holds while en=0.
REQ-018 The terminal value is modulo when dir=1 and 0 when dir=0.
REQ-019 Priority is reset > load > start > tick.
REQ-020 Load: count <= min(load_val, modulo); the prescaler clears to 0; tc is 0 that cycle; FSM state and done are unchanged.
REQ-021 Wrap mode: on a tick, count steps by ±1. At the terminal value, count instead goes to 0 (up) or modulo (down), and tc=1 on the following cycle.
REQ-022 Saturate mode: on a tick, count steps by ±1 but never past the terminal value. tc=1 only for the tick that moves count onto the terminal value. Ticks taken at the terminal value hold count and do not pulse tc.
REQ-023 One-shot FSM states are IDLE, RUN and DONE.
  - IDLE→RUN on start: count <= 0 (up) or modulo (down); prescaler clears.
  - RUN: counts ticks as in saturate mode. The tick reaching the terminal value goes to DONE with tc=1 and done=1.
  - DONE→RUN on start, reinitialising as for IDLE→RUN; done clears.
  - start is ignored in wrap and saturate modes.
REQ-024 running equals en in wrap and saturate modes, and (en and state==RUN) in one-shot mode.
REQ-025 If mode leaves one-shot, the FSM goes to IDLE and done clears on the next edge; count is retained.
REQ-026 modulo=0: count stays 0. Wrap mode pulses tc on every tick; saturate and one-shot modes pulse tc on no tick; one-shot start goes to DONE on the first tick.
REQ-027 If count > modulo because modulo was lowered, the next tick loads the terminal value of the current direction; no tc pulse.
REQ-028 A dir change takes effect on the next tick; no extra tc pulse.
REQ-029 All arithmetic is WIDTH-bit unsigned; no wider intermediate values are exposed.

Reset
REQ-030 Asserting reset immediately forces count=0, tc=0, done=0, running=0, prescaler=0 and FSM=IDLE, including mid-count or mid-one-shot.
REQ-031 The first tick after reset release occurs presc+1 enabled cycles after release.

Structure
REQ-032 Shared package prog_counter_pkg holds the mode encoding constants and the one-shot FSM state typedef.
REQ-033 The prescaler is the single sub-module tick_prescaler (parameter PRESC_W; ports clk, reset, en, clr, presc, tick).
REQ-034 The counter datapath and the FSM reside in prog_counter.

Verification
REQ-035 WIDTH=8, wrap, up, modulo=9, presc=0, en=1 → count 0..9,0,…; tc high exactly on the cycle count shows 0 after 9.
REQ-036 Saturate, down, load_val=3, presc=2 → count 3,2,1,0 with one change every 3 cycles; a single tc pulse on reaching 0; count holds 0.
REQ-037 One-shot, up, modulo=4, presc=0, start → count 0..4, tc and done on reaching 4, running=0; a second start → done clears and count restarts at 0.
REQ-038 Wrap, count=5, load=1 and tick in the same cycle, load_val=200, modulo=50 → count=50, no tc.
REQ-039 Reset asserted mid-one-shot at count=2 → all outputs zero asynchronously; after release, no counting until a new start.
REQ-040 Wrap, modulo=0 → count stays 0 and tc pulses on every tick; en=0 → prescaler and count freeze and tc stays 0.
